mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_alu.sv | 71 +++++++
 rtl/mdu.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// sequencer states and the latency counter width.
package mdu_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mdu_alu.sv
// Combinational multiply/divide datapath producing the full {hi,lo} result
// and a divide-by-zero flag; latency is modelled by the sequencer in mdu.
import mdu_pkg::*;

module mdu_alu (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  mdu_op_t     op_s;
  logic [63:0] smul_s;
  logic [63:0] umul_s;
  logic        b_zero_s;
  logic [31:0] udiv_b_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] sdiv_b_s;
  logic [31:0] sq_mag_s;
  logic [31:0] sr_mag_s;
  logic [31:0] sq_s;
  logic [31:0] sr_s;

  assign op_s     = mdu_op_t'(op);
  assign b_zero_s = (b == 32'd0);

  assign smul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign umul_s = {32'd0, a} * {32'd0, b};

  // A zero divisor is replaced by one so the dividers never see it; the
  // result is discarded by the sequencer anyway.
  assign udiv_b_s = b_zero_s ? 32'd1 : b;
  assign uq_s     = a / udiv_b_s;
  assign ur_s     = a % udiv_b_s;

  // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow case.
  assign abs_a_s  = a[31] ? (32'd0 - a) : a;
  assign abs_b_s  = b[31] ? (32'd0 - b) : b;
  assign sdiv_b_s = b_zero_s ? 32'd1 : abs_b_s;
  assign sq_mag_s = abs_a_s / sdiv_b_s;
  assign sr_mag_s = abs_a_s % sdiv_b_s;
  assign sq_s     = (a[31] ^ b[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
  assign sr_s     = a[31] ? (32'd0 - sr_mag_s) : sr_mag_s;

  // Result select by operation.
  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op_s)
      MULT:    result = smul_s;
      MULTU:   result = umul_s;
      DIV: begin
        result      = {sr_s, sq_s};
        div_by_zero = b_zero_s;
      end
      DIVU: begin
        result      = {ur_s, uq_s};
        div_by_zero = b_zero_s;
      end
      default: begin
        result      = 64'd0;
        div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit sequencer: launches an operation from IDLE, holds busy
// for the configured latency, then commits the pending result to HI/LO.
import mdu_pkg::*;

module mdu #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  mdu_state_t       state_r;
  mdu_state_t       state_nx_s;
  mdu_op_t          op_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] lat_s;
  logic             busy_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      pend_hi_r;
  logic [31:0]      pend_lo_r;
  logic             pend_wr_r;
  logic             launch_s;
  logic             done_s;
  logic             mthi_s;
  logic             mtlo_s;
  logic [63:0]      alu_res_s;
  logic             alu_dz_s;

  assign op_s = mdu_op_t'(mdu_op);
  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  mdu_alu u_alu (
    .op          (mdu_op),
    .a           (a),
    .b           (b),
    .result      (alu_res_s),
    .div_by_zero (alu_dz_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) state_nx_s = RUN;
        else          state_nx_s = IDLE;
      end
      RUN: begin
        if (cnt_r == 4'd1) state_nx_s = IDLE;
        else               state_nx_s = RUN;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Control decode; starts are only honoured in IDLE.
  always_comb begin
    launch_s = 1'b0;
    done_s   = 1'b0;
    mthi_s   = 1'b0;
    mtlo_s   = 1'b0;
    lat_s    = 4'd0;
    case (state_r)
      IDLE: begin
        if (start) begin
          case (op_s)
            MULT, MULTU: begin
              launch_s = 1'b1;
              lat_s    = MULT_CNT;
            end
            DIV, DIVU: begin
              launch_s = 1'b1;
              lat_s    = DIV_CNT;
            end
            MTHI:    mthi_s = 1'b1;
            MTLO:    mtlo_s = 1'b1;
            default: launch_s = 1'b0;
          endcase
        end else begin
          launch_s = 1'b0;
        end
      end
      RUN: begin
        if (cnt_r == 4'd1) done_s = 1'b1;
        else               done_s = 1'b0;
      end
      default: done_s = 1'b0;
    endcase
  end

  // Counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= 4'd0;
      busy_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      if (launch_s) begin
        cnt_r     <= lat_s;
        pend_hi_r <= alu_res_s[63:32];
        pend_lo_r <= alu_res_s[31:0];
        pend_wr_r <= ~alu_dz_s;
      end else if (state_r == RUN) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end

      busy_r <= (state_nx_s == RUN);

      // A divide by zero completes without touching HI/LO.
      if (done_s && pend_wr_r) begin
        hi_r <= pend_hi_r;
        lo_r <= pend_lo_r;
      end else begin
        if (mthi_s) hi_r <= a;
        else        hi_r <= hi_r;
        if (mtlo_s) lo_r <= a;
        else        lo_r <= lo_r;
      end
    end
  end

endmodule
